pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, forwarding and halt-drain controller for the in-order 16-bit pipeline. It sits beside the ID stage and keeps its own scoreboard of in-flight instructions, one slot per post-ID stage (EX..WB). From that scoreboard it produces stall, flush, bubble and freeze controls, and per-operand forwarding selects for EX. It replaces separate hazard and forwarding units, generalising them to arbitrary depth and register count, and adds multi-cycle memory freeze and clean halt draining.

Parameters:
NUM_REGS, 16, architectural register count; register 0 reads as zero and is never a hazard or forward source.
REG_W, $clog2(NUM_REGS), register index width (derived).
PIPE_DEPTH, 3, post-ID stages tracked; slot 0 = EX, slot PIPE_DEPTH-1 = WB; must be >= 2.
SEL_W, $clog2(PIPE_DEPTH), forward-select width (derived).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs / id_rt  in  REG_W  ID source registers
id_rs_used / id_rt_used  in  1  source is actually read
id_rd  in  REG_W  ID destination register
id_reg_write  in  1  ID instruction writes id_rd
id_mem_read  in  1  ID instruction is a load
id_branch  in  1  ID instruction is a branch (resolved in ID)
id_br_taken  in  1  branch condition true (valid with id_branch)
id_hlt  in  1  ID instruction is HLT
mem_busy  in  1  data memory not ready; freeze all stages
stall_if_id  out  1  hold PC and IF/ID register
flush_if_id  out  1  squash IF/ID next edge
bubble_ex  out  1  insert NOP into ID/EX
freeze  out  1  hold every pipeline register
fwd_rs_sel / fwd_rt_sel  out  SEL_W  EX operand source: 0 = ID/EX register value, k = result held in slot k
inflight  out  $clog2(PIPE_DEPTH+1)  valid scoreboard slots
hlt  out  1  pipeline drained after HLT; sticky

Behaviour:
- Reset (async, rst_n low): all slots invalid, FSM = RUN, all outputs 0, fwd selects 0.
- Scoreboard slot: {valid, rd, reg_write, mem_read, rs, rt}. Each non-frozen edge shifts slot k into k+1 and drops slot PIPE_DEPTH-1. Slot 0 loads the ID fields, or an invalid entry when bubble_ex or !id_valid.
- Match(k, r): slot k valid, reg_write set, rd == r, r != 0.
- Load-use: ID source matches slot 0 with mem_read set -> stall_if_id = 1, bubble_ex = 1. Lasts exactly 1 cycle per load.
- Branch hazard: id_branch and a source matches slot 0, or matches slot 1 with mem_read -> stall + bubble until clear.
- Taken branch with no hazard -> flush_if_id = 1 for one cycle. Stall suppresses the flush; the flush is re-evaluated after the stall clears.
- Forwarding (combinational on slot 0 rs/rt): select the lowest k in 1..PIPE_DEPTH-1 with Match(k, src); the youngest producer wins. Otherwise 0.
- freeze = mem_busy. While frozen: scoreboard holds, stall/flush/bubble forced 0, FSM holds. Priority: freeze > stall > flush.
- FSM:
  - RUN: on id_valid & id_hlt & no stall & !freeze -> DRAIN. HLT itself is not entered into the scoreboard.
  - DRAIN: stall_if_id = 1; slot 0 loads invalid. When inflight == 0 -> HALTED.
  - HALTED: hlt = 1, stall_if_id = 1. Leaves only via reset.
- hlt rises the cycle after the last valid slot leaves WB. Reset mid-DRAIN returns to RUN with an empty scoreboard.
- All outputs except hlt, inflight and the FSM state are combinational from the scoreboard and ID inputs.

Decomposition:
- Shared package hazard_pkg: FSM state enum (RUN, DRAIN, HALTED) and the scoreboard slot struct typedef.
- One sub-module, hazard_scoreboard_slot: a single slot register with shift/hold/load control, instantiated PIPE_DEPTH times through generate.

Test Plan:
- LDW R3 then ADD R4,R3,R5 back-to-back -> one cycle of stall_if_id = 1 and bubble_ex = 1; then fwd_rs_sel = 2 (WB) for the ADD in EX.
- ADD R1 then SUB R2,R1,R1 -> no stall; fwd_rs_sel = fwd_rt_sel = 1.
- ADD R1 in slot 1 and ADD R1 in slot 2, EX reads R1 -> fwd_rs_sel = 1 (youngest producer).
- Taken branch reading R2 one cycle after ADD R2 -> 1 stall cycle, then flush_if_id = 1 for exactly 1 cycle; an untaken branch gives no flush.
- mem_busy held 3 cycles during a load in MEM -> freeze = 1 for 3 cycles, inflight unchanged, no flush/stall asserted, normal progress after release.
- HLT with 3 instructions in flight -> DRAIN, inflight counts 3,2,1,0, hlt = 1 the next cycle and stays 1; rst_n low mid-DRAIN -> hlt = 0, inflight = 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// FSM states, the scoreboard slot layout and the slot match helper.
package hazard_pkg;

    localparam int MAX_REG_W = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    // Register fields are stored at a fixed maximum width so the struct stays parameter-free.
    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic [MAX_REG_W-1:0] rs;
        logic [MAX_REG_W-1:0] rt;
    } slot_t;

    function automatic logic slot_match(input slot_t s, input logic [MAX_REG_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != {MAX_REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One scoreboard slot: loads its input on every non-frozen edge, holds otherwise.
module hazard_scoreboard_slot
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  slot_t d,
    output slot_t q
);

    // Slot register with shift/hold control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the in-order pipeline.
// Tracks one scoreboard slot per post-ID stage (slot 0 = EX, last slot = WB).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int REG_W      = $clog2(NUM_REGS),
    parameter int PIPE_DEPTH = 3,
    parameter int SEL_W      = $clog2(PIPE_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            id_valid,
    input  logic [REG_W-1:0]                id_rs,
    input  logic [REG_W-1:0]                id_rt,
    input  logic                            id_rs_used,
    input  logic                            id_rt_used,
    input  logic [REG_W-1:0]                id_rd,
    input  logic                            id_reg_write,
    input  logic                            id_mem_read,
    input  logic                            id_branch,
    input  logic                            id_br_taken,
    input  logic                            id_hlt,
    input  logic                            mem_busy,
    output logic                            stall_if_id,
    output logic                            flush_if_id,
    output logic                            bubble_ex,
    output logic                            freeze,
    output logic [SEL_W-1:0]                fwd_rs_sel,
    output logic [SEL_W-1:0]                fwd_rt_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] inflight,
    output logic                            hlt
);

    localparam int CNT_W = $clog2(PIPE_DEPTH+1);

    hz_state_e            state_r, state_d_s;
    slot_t                slot_q_s [PIPE_DEPTH];
    slot_t                slot_d_s [PIPE_DEPTH];
    slot_t                id_entry_s;
    logic [CNT_W-1:0]     inflight_r, inflight_d_s;
    logic [MAX_REG_W-1:0] src_rs_s, src_rt_s;
    logic                 near_s, load_far_s, hazard_s, load_s;
    logic                 stall_s, flush_s, bubble_s;
    logic                 unused_tail_s;

    // Unused sources are mapped to register 0, which never matches.
    assign src_rs_s = id_rs_used ? MAX_REG_W'(id_rs) : {MAX_REG_W{1'b0}};
    assign src_rt_s = id_rt_used ? MAX_REG_W'(id_rt) : {MAX_REG_W{1'b0}};

    assign near_s     = slot_match(slot_q_s[0], src_rs_s) || slot_match(slot_q_s[0], src_rt_s);
    assign load_far_s = slot_q_s[1].mem_read &&
                        (slot_match(slot_q_s[1], src_rs_s) || slot_match(slot_q_s[1], src_rt_s));

    // Load-use (EX load) and branch-operand hazards for the instruction in ID.
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid) begin
            hazard_s = (near_s && slot_q_s[0].mem_read) || (id_branch && (near_s || load_far_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Next-state and control outputs; freeze overrides everything.
    always_comb begin
        state_d_s = state_r;
        stall_s   = 1'b0;
        flush_s   = 1'b0;
        bubble_s  = 1'b0;
        load_s    = 1'b0;
        if (mem_busy) begin
            state_d_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    stall_s  = hazard_s;
                    bubble_s = hazard_s;
                    flush_s  = id_valid && id_branch && id_br_taken && !hazard_s;
                    load_s   = id_valid && !hazard_s && !id_hlt;
                    if (id_valid && id_hlt && !hazard_s) begin
                        state_d_s = DRAIN;
                    end else begin
                        state_d_s = RUN;
                    end
                end
                DRAIN: begin
                    stall_s = 1'b1;
                    if (inflight_r == {CNT_W{1'b0}}) begin
                        state_d_s = HALTED;
                    end else begin
                        state_d_s = DRAIN;
                    end
                end
                HALTED: begin
                    stall_s   = 1'b1;
                    state_d_s = HALTED;
                end
                default: begin
                    state_d_s = RUN;
                end
            endcase
        end
    end

    // Entry presented to slot 0: the ID instruction or an empty slot.
    always_comb begin
        id_entry_s = '0;
        if (load_s) begin
            id_entry_s.valid     = 1'b1;
            id_entry_s.rd        = MAX_REG_W'(id_rd);
            id_entry_s.reg_write = id_reg_write;
            id_entry_s.mem_read  = id_mem_read;
            id_entry_s.rs        = src_rs_s;
            id_entry_s.rt        = src_rt_s;
        end else begin
            id_entry_s = '0;
        end
    end

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign slot_d_s[g] = id_entry_s;
        end else begin : g_tail
            assign slot_d_s[g] = slot_q_s[g-1];
        end
        hazard_scoreboard_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (!mem_busy),
            .d     (slot_d_s[g]),
            .q     (slot_q_s[g])
        );
    end

    // Occupancy after the coming edge, so the registered count tracks the slots exactly.
    always_comb begin
        inflight_d_s = inflight_r;
        if (!mem_busy) begin
            inflight_d_s = {CNT_W{1'b0}};
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                inflight_d_s = inflight_d_s + CNT_W'(slot_d_s[k].valid);
            end
        end else begin
            inflight_d_s = inflight_r;
        end
    end

    // FSM state and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_d_s;
            inflight_r <= inflight_d_s;
        end
    end

    // Forward selects: scanning oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_rs_sel = {SEL_W{1'b0}};
        fwd_rt_sel = {SEL_W{1'b0}};
        for (int k = PIPE_DEPTH-1; k >= 1; k--) begin
            if (slot_match(slot_q_s[k], slot_q_s[0].rs)) begin
                fwd_rs_sel = SEL_W'(k);
            end else begin
                fwd_rs_sel = fwd_rs_sel;
            end
            if (slot_match(slot_q_s[k], slot_q_s[0].rt)) begin
                fwd_rt_sel = SEL_W'(k);
            end else begin
                fwd_rt_sel = fwd_rt_sel;
            end
        end
    end

    assign unused_tail_s = ^{slot_q_s[PIPE_DEPTH-1].mem_read,
                             slot_q_s[PIPE_DEPTH-1].rs,
                             slot_q_s[PIPE_DEPTH-1].rt};

    assign stall_if_id = stall_s;
    assign flush_if_id = flush_s;
    assign bubble_ex   = bubble_s;
    assign freeze      = mem_busy;
    assign inflight    = inflight_r;
    assign hlt         = (state_r == HALTED);

endmodule
